// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter wrapped around an external 8-bit 4:1 mux.
// Chooses a requesting source, steers the mux selects to it, captures the mux
// output into a register and offers that word on a valid/ready port.
module mux4_rr_arbiter #(
  parameter int         WIDTH      = 8,
  parameter logic [1:0] RESET_LAST = 2'd3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [3:0]       gnt,
  output logic             s0,
  output logic             s1,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         last_q, last_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic [1:0]         winner;

  // Scan from the largest offset down so the nearest requester after 'last'
  // overwrites the others; offset 4 wraps back onto 'last' itself.
  function automatic logic [1:0] pickWinner(input logic [1:0] last,
                                            input logic [3:0] r);
    logic [1:0] idx;
    logic [1:0] found;
    found = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) found = idx;
    end
    return found;
  endfunction

  assign winner = pickWinner(last_q, req);

  // State and datapath registers; reset drops any pending word and restores priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      last_q  <= RESET_LAST;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic: select in IDLE, capture in SEL, hand off in HOLD.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = winner;
          state_d = SEL;
        end
      end
      SEL: begin
        data_d  = y;
        valid_d = 1'b1;
        last_d  = sel_q;
        state_d = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (|req) begin
            sel_d   = winner;
            state_d = SEL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Moore outputs: grant only while the selected word is being captured.
  always_comb begin
    gnt       = 4'b0000;
    if (state_q == SEL) gnt[sel_q] = 1'b1;
    s0        = sel_q[1];
    s1        = sel_q[0];
    out_data  = data_q;
    out_valid = valid_q;
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s0, s1;
  logic [7:0] y;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] src [4];

  int checks = 0;
  int errors = 0;

  // Reference model: which source is being granted (-1 none), whether a word
  // is waiting for the consumer, and which source was served last.
  int         mGrant    = -1;
  bit         mHeld     = 1'b0;
  int         mSel      = 0;
  int         mLast     = 3;
  logic [7:0] mData     = 8'h00;
  int         mCaptured = -1;
  bit         modelOn   = 1'b0;
  bit         refreshEn = 1'b0;

  always #5 clk = ~clk;

  // The mux sitting between the sources and the arbiter.
  assign y = src[{s0, s1}];

  mux4_rr_arbiter #(.WIDTH(8), .RESET_LAST(2'd3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .s0        (s0),
    .s1        (s1),
    .y         (y),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic int pickWinner(input int last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (last + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model at each rising edge from the inputs the DUT also sees.
  always @(posedge clk) begin
    mCaptured = -1;
    if (!rst_n) begin
      mGrant = -1;
      mHeld  = 1'b0;
      mSel   = 0;
      mLast  = 3;
      mData  = 8'h00;
    end else if (mGrant >= 0) begin
      mData     = src[mGrant];
      mHeld     = 1'b1;
      mLast     = mGrant;
      mCaptured = mGrant;
      mGrant    = -1;
    end else if (mHeld) begin
      if (out_ready) begin
        mHeld = 1'b0;
        if (req != 4'b0000) begin
          mGrant = pickWinner(mLast, req);
          mSel   = mGrant;
        end
      end
    end else if (req != 4'b0000) begin
      mGrant = pickWinner(mLast, req);
      mSel   = mGrant;
    end
  end

  task automatic checkOutput();
    logic [3:0] expGnt;
    expGnt = (mGrant >= 0) ? (4'b0001 << mGrant) : 4'b0000;
    check("gnt", 32'(gnt), 32'(expGnt));
    check("sel", 32'({s0, s1}), 32'(mSel));
    check("out_valid", 32'(out_valid), 32'(mHeld));
    check("out_data", 32'(out_data), 32'(mData));
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("gnt_vs_valid", 32'((|gnt) && out_valid), 32'd0);
  endtask

  // Compare the DUT against the model on every falling edge once reset has taken.
  always @(negedge clk) begin
    if (modelOn) checkOutput();
  end

  // Drive one cycle of inputs just after a falling edge, then wait for the next one.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rdy);
    #1;
    if (refreshEn && mCaptured >= 0) src[mCaptured] = 8'($urandom);
    rst_n     = r;
    req       = rq;
    out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] words [$];
    logic [7:0] expWords [5];
    expWords[0] = 8'hA4; expWords[1] = 8'h0F; expWords[2] = 8'h1D;
    expWords[3] = 8'h9C; expWords[4] = 8'hA4;
    rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0;
    src[0] = 8'hA4; src[1] = 8'h0F; src[2] = 8'h1D; src[3] = 8'h9C;

    // Reset held across two edges.
    @(negedge clk);
    applyStimulus(1'b0, 4'b0000, 1'b0);
    modelOn = 1'b1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_sel", 32'({s0, s1}), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);

    // Single request from source 2.
    applyStimulus(1'b1, 4'b0100, 1'b1);
    check("single_sel", 32'({s0, s1}), 32'b10);
    check("single_gnt", 32'(gnt), 32'b0100);
    applyStimulus(1'b1, 4'b0100, 1'b1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'h1D);
    check("single_gnt_off", 32'(gnt), 32'd0);
    applyStimulus(1'b1, 4'b0000, 1'b1);
    check("single_idle", 32'(out_valid), 32'd0);

    // Round-robin with all sources requesting, starting from fresh priority.
    applyStimulus(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'b1111, 1'b1);
      if (out_valid) words.push_back(out_data);
    end
    check("rr_count", 32'(words.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < words.size()) check($sformatf("rr_word%0d", i), 32'(words[i]), 32'(expWords[i]));
      else check($sformatf("rr_word%0d", i), 32'hFFFF_FFFF, 32'(expWords[i]));
    end

    // Backpressure while a word is held (A4 from source 0).
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b1111, 1'b0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'hA4);
      check("bp_gnt", 32'(gnt), 32'd0);
    end
    applyStimulus(1'b1, 4'b1111, 1'b1);
    check("bp_release_gnt", 32'(gnt), 32'b0010);
    check("bp_release_valid", 32'(out_valid), 32'd0);

    // Wrap priority: after reset source 0 wins, then source 3.
    applyStimulus(1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b1, 4'b1001, 1'b1);
    check("wrap_gnt0", 32'(gnt), 32'b0001);
    applyStimulus(1'b1, 4'b1001, 1'b1);
    check("wrap_data0", 32'(out_data), 32'hA4);
    applyStimulus(1'b1, 4'b1001, 1'b1);
    check("wrap_gnt3", 32'(gnt), 32'b1000);

    // Reset while holding a word.
    applyStimulus(1'b1, 4'b0000, 1'b0);
    check("hold_valid", 32'(out_valid), 32'd1);
    check("hold_data", 32'(out_data), 32'h9C);
    applyStimulus(1'b0, 4'b1111, 1'b1);
    check("rsthold_valid", 32'(out_valid), 32'd0);
    check("rsthold_gnt", 32'(gnt), 32'd0);
    applyStimulus(1'b1, 4'b1111, 1'b1);
    check("rsthold_gnt0", 32'(gnt), 32'b0001);

    // Randomized traffic with fresh data after each grant and occasional resets.
    refreshEn = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      logic r;
      logic rdy;
      r   = ($urandom_range(0, 99) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r, 4'($urandom), rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
